fetch: RTL and testbench

//  IF stage of the rv32i 5-stage pipeline; sits directly upstream of decode and drives its
//  FE/DE stage register (fe_de_stage_reg_t) plus the matching rvfi_t monitor bundle.

---
 rtl/rv32i_types.sv | 36 +++
 rtl/fetch.sv | 120 ++++++++++++
 tb/tb_fetch.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared rv32i pipeline types: FE/DE stage register, RVFI monitor bundle, fetch FSM states.
package rv32i_types;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } fe_de_stage_reg_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] inst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rvfi_t;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch.sv
// IF stage: owns the PC, one outstanding imem request, holds a response across decode stalls.
// Response lands in FE/DE on the resp edge; redirects squash in-flight and held fetches.
module fetch
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  input  logic [63:0]      redirect_order,
  output logic [31:0]      imem_addr,
  output logic [3:0]       imem_rmask,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_resp,
  output fe_de_stage_reg_t DE_stage_reg,
  output rvfi_t            DE_rvfi_monitor
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc_q, pc_nxt, hold_q;
  logic [63:0]  order_q;
  logic         hold_ld, deliver;
  logic [31:0]  deliver_instr;

  assign imem_addr = pc_q;

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc_q;
    hold_ld       = 1'b0;
    deliver       = 1'b0;
    deliver_instr = imem_rdata;
    imem_rmask    = 4'h0;
    case (state)
      ISSUE: begin
        imem_rmask = rst ? 4'h0 : 4'hF;
        state_nxt  = redirect ? FLUSH : WAIT;
      end
      WAIT: begin
        // A response coincident with a redirect is already the squashed one.
        if (redirect)       state_nxt = imem_resp ? ISSUE : FLUSH;
        else if (imem_resp) begin
          if (stall) begin
            hold_ld   = 1'b1;
            state_nxt = HOLD;
          end else begin
            deliver   = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      FLUSH: begin
        if (imem_resp) state_nxt = ISSUE;
      end
      HOLD: begin
        if (redirect) state_nxt = ISSUE;
        else if (!stall) begin
          deliver       = 1'b1;
          deliver_instr = hold_q;
          state_nxt     = ISSUE;
        end
      end
      default: state_nxt = ISSUE;
    endcase
    if (redirect)     pc_nxt = redirect_pc;
    else if (deliver) pc_nxt = pc_q + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ISSUE;
      pc_q    <= RESET_PC;
      order_q <= 64'd0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
      if (redirect)     order_q <= redirect_order + 64'd1;
      else if (deliver) order_q <= order_q + 64'd1;
      if (hold_ld)      hold_q  <= imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      DE_stage_reg.valid <= 1'b0;
      DE_stage_reg.pc    <= RESET_PC;
      DE_stage_reg.instr <= 'x;
    end else if (redirect) begin
      DE_stage_reg.valid <= 1'b0;
    end else if (!stall) begin
      if (deliver) DE_stage_reg <= '{pc: pc_q, instr: deliver_instr, valid: 1'b1};
      else         DE_stage_reg.valid <= 1'b0;
    end
  end

  // Only the fetch-owned RVFI fields are driven; the rest stay unknown for later stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      DE_rvfi_monitor          <= 'x;
      DE_rvfi_monitor.valid    <= 1'b0;
      DE_rvfi_monitor.order    <= 64'd0;
      DE_rvfi_monitor.pc_rdata <= 32'd0;
    end else if (redirect) begin
      DE_rvfi_monitor.valid <= 1'b0;
    end else if (!stall) begin
      if (deliver) begin
        DE_rvfi_monitor.valid    <= 1'b1;
        DE_rvfi_monitor.order    <= order_q;
        DE_rvfi_monitor.inst     <= deliver_instr;
        DE_rvfi_monitor.pc_rdata <= pc_q;
      end else begin
        DE_rvfi_monitor.valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: variable-latency imem model plus a transaction-level fetch reference.
module tb_fetch;
  import rv32i_types::*;

  localparam logic [31:0] RST_PC = 32'h1eceb000;

  logic             clk = 1'b0;
  logic             rst, stall, redirect, imem_resp;
  logic [31:0]      redirect_pc, imem_addr, imem_rdata;
  logic [63:0]      redirect_order;
  logic [3:0]       imem_rmask;
  fe_de_stage_reg_t de;
  rvfi_t            rv;

  fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .redirect_order(redirect_order),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .DE_stage_reg(de), .DE_rvfi_monitor(rv)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // memory: one pending request, latency drawn from [lat_lo, lat_hi]
  bit          pend;
  int          pend_cnt;
  logic [31:0] pend_addr;
  int          lat_lo = 1, lat_hi = 1;

  // reference: fetch PC, in-flight request, held word, expected FE/DE + rvfi contents
  logic [31:0] m_pc, m_held_w, m_de_pc, m_de_instr, m_rv_inst, m_rv_pc;
  logic [63:0] m_order, m_rv_order;
  bit          m_infl, m_infl_sq, m_held, m_de_valid, m_rv_valid;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0000_0013;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_order = 64'd0;
    m_infl = 0; m_infl_sq = 0; m_held = 0;
    m_de_valid = 0; m_rv_valid = 0;
  endtask

  // Called just after a clock edge: produce this cycle's memory response, check outputs.
  task automatic start_cycle();
    bit issue_exp;
    imem_resp  = 1'b0;
    imem_rdata = $urandom;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_resp  = 1'b1;
        imem_rdata = word_at(pend_addr);
        pend       = 0;
      end
    end
    issue_exp = !m_infl && !m_held;
    chk("imem_rmask", 64'(imem_rmask), issue_exp ? 64'hF : 64'h0);
    if (issue_exp) chk("imem_addr", 64'(imem_addr), 64'(m_pc));
    if (imem_rmask == 4'hF) begin
      pend      = 1;
      pend_cnt  = $urandom_range(lat_hi, lat_lo);
      pend_addr = imem_addr;
    end
    chk("de_valid", 64'(de.valid), 64'(m_de_valid));
    if (m_de_valid) begin
      chk("de_pc", 64'(de.pc), 64'(m_de_pc));
      chk("de_instr", 64'(de.instr), 64'(m_de_instr));
    end
    chk("rvfi_valid", 64'(rv.valid), 64'(m_rv_valid));
    if (m_rv_valid) begin
      chk("rvfi_order", rv.order, m_rv_order);
      chk("rvfi_inst", 64'(rv.inst), 64'(m_rv_inst));
      chk("rvfi_pc", 64'(rv.pc_rdata), 64'(m_rv_pc));
    end
  endtask

  // Drive one cycle of control inputs, advance the reference, move to the next cycle.
  task automatic cycle(input bit st, input bit rd, input logic [31:0] rpc, input logic [63:0] rord);
    bit          issue, dv;
    logic [31:0] dw;
    stall = st; redirect = rd; redirect_pc = rpc; redirect_order = rord;
    issue = !m_infl && !m_held;
    dv = 0; dw = 32'd0;
    if (m_held && !rd && !st) begin
      dv = 1; dw = m_held_w; m_held = 0;
    end
    if (imem_resp) begin
      m_infl = 0;
      if (!m_infl_sq && !rd) begin
        if (st) begin m_held = 1; m_held_w = imem_rdata; end
        else    begin dv = 1; dw = imem_rdata; end
      end
    end
    if (issue) begin m_infl = 1; m_infl_sq = 0; end
    if (rd) begin
      m_pc = rpc; m_infl_sq = 1; m_held = 0; m_order = rord + 64'd1;
      m_de_valid = 0; m_rv_valid = 0;
    end else if (!st) begin
      if (dv) begin
        m_de_valid = 1; m_de_pc = m_pc; m_de_instr = dw;
        m_rv_valid = 1; m_rv_order = m_order; m_rv_inst = dw; m_rv_pc = m_pc;
        m_order = m_order + 64'd1;
        m_pc = m_pc + 32'd4;
      end else begin
        m_de_valid = 0; m_rv_valid = 0;
      end
    end
    @(posedge clk); #1;
    start_cycle();
  endtask

  task automatic do_reset(input int n);
    rst = 1; stall = 0; redirect = 0; imem_resp = 0; pend = 0;
    repeat (n) begin
      @(posedge clk); #1;
      chk("rmask_in_rst", 64'(imem_rmask), 64'h0);
    end
    chk("rst_de_valid", 64'(de.valid), 64'h0);
    chk("rst_de_pc", 64'(de.pc), 64'(RST_PC));
    chk("rst_rvfi_valid", 64'(rv.valid), 64'h0);
    chk("rst_rvfi_order", rv.order, 64'h0);
    chk("rst_rvfi_pc", 64'(rv.pc_rdata), 64'h0);
    chk("rst_imem_addr", 64'(imem_addr), 64'(RST_PC));
    model_reset();
    rst = 0;
    #1;
    start_cycle();
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 32'd0, 64'd0);
  endtask

  task automatic wait_resp(input int max);
    for (int i = 0; i < max && !imem_resp; i++) cycle(0, 0, 32'd0, 64'd0);
    if (!imem_resp) chk("resp_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_issue(input int max);
    for (int i = 0; i < max && imem_rmask != 4'hF; i++) cycle(0, 0, 32'd0, 64'd0);
    if (imem_rmask != 4'hF) chk("issue_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    stall = 0; redirect = 0; redirect_pc = 0; redirect_order = 0;
    imem_resp = 0; imem_rdata = 0;

    // 1: straight-line fetch, 1-cycle memory
    lat_lo = 1; lat_hi = 1;
    do_reset(2);
    run_idle(8);

    // 2: stall on the response of RESET_PC+4, release after 3 cycles
    do_reset(1);
    wait_resp(8);
    cycle(0, 0, 32'd0, 64'd0);
    wait_resp(8);
    cycle(1, 0, 32'd0, 64'd0);
    chk("s2_hold_pc", 64'(de.pc), 64'(RST_PC));
    cycle(1, 0, 32'd0, 64'd0);
    cycle(1, 0, 32'd0, 64'd0);
    cycle(0, 0, 32'd0, 64'd0);
    chk("s2_rel_pc", 64'(de.pc), 64'(RST_PC + 32'd4));
    chk("s2_rel_order", rv.order, 64'd1);
    run_idle(4);

    // 3: redirect while waiting on a 3-cycle memory
    lat_lo = 3; lat_hi = 3;
    wait_issue(10);
    cycle(0, 0, 32'd0, 64'd0);
    cycle(0, 1, 32'h1eceb100, 64'd5);
    wait_issue(10);
    chk("s3_addr", 64'(imem_addr), 64'h1eceb100);
    wait_resp(10);
    cycle(0, 0, 32'd0, 64'd0);
    chk("s3_order", rv.order, 64'd6);

    // 4: redirect coincident with the response
    lat_lo = 2; lat_hi = 2;
    wait_resp(10);
    cycle(0, 1, 32'h1eceb200, 64'd20);
    chk("s4_de_valid", 64'(de.valid), 64'd0);
    chk("s4_rmask", 64'(imem_rmask), 64'hF);
    chk("s4_addr", 64'(imem_addr), 64'h1eceb200);
    run_idle(6);

    // 5: redirect while holding under stall
    wait_resp(10);
    cycle(1, 0, 32'd0, 64'd0);
    cycle(1, 1, 32'h1eceb300, 64'd30);
    chk("s5_de_valid", 64'(de.valid), 64'd0);
    chk("s5_addr", 64'(imem_addr), 64'h1eceb300);
    run_idle(6);

    // 6: reset mid-request
    wait_issue(10);
    cycle(0, 0, 32'd0, 64'd0);
    do_reset(2);
    chk("s6_addr", 64'(imem_addr), 64'(RST_PC));
    run_idle(4);

    // PC wrap at the top of the address space
    lat_lo = 1; lat_hi = 1;
    cycle(0, 1, 32'hFFFF_FFFC, 64'd100);
    run_idle(12);

    // randomized traffic
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(199, 0) == 0) do_reset(1);
      else cycle($urandom_range(9, 0) < 3, $urandom_range(11, 0) == 0,
                 $urandom & 32'hFFFF_FFFC, {32'd0, $urandom});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
